// File: rtl/imem_loader.sv
// imem_loader: instruction memory filled from an 8-bit little-endian byte
// stream. The core is held in reset while loading. Afterwards the block
// serves combinational instruction fetches.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (running XOR of loaded words).
module imem_loader #(
    parameter int unsigned DEPTH = 256
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        load_start,
    input  logic [7:0]  load_last,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    input  logic [7:0]  fetch_addr,
    output logic [31:0] fetch_data,
    output logic        core_hold,
    output logic        load_done,
    output logic [8:0]  words_loaded,
    output logic [31:0] checksum
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [AW-1:0]   ptr_q;
    logic [AW-1:0]   last_q;
    logic [1:0]      lane_q;
    logic [23:0]     part_q;
    logic            start_c;
    logic            accept_c;
    logic            word_c;
    logic [31:0]     word_data_c;
    logic [31:0]     mem [DEPTH];

    // Lane 3 byte completes the word on top of the three buffered lanes.
    assign word_data_c = {byte_in, part_q};

    // State register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control strobes.
    always_comb begin
        state_d  = state_q;
        start_c  = 1'b0;
        accept_c = 1'b0;
        word_c   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (load_start) begin
                    start_c = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                accept_c = byte_valid & byte_ready;
                word_c   = accept_c && (lane_q == 2'd3);
                if (word_c && (ptr_q == last_q)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered status outputs, decoded from the next state.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            byte_ready <= 1'b0;
            core_hold  <= 1'b1;
            load_done  <= 1'b0;
        end else begin
            byte_ready <= (state_d == LOAD);
            core_hold  <= (state_d != DONE);
            load_done  <= (state_d == DONE);
        end
    end

    // Load bookkeeping: pointer, lane, partial word and word count.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ptr_q        <= '0;
            last_q       <= '0;
            lane_q       <= 2'd0;
            part_q       <= 24'd0;
            words_loaded <= 9'd0;
        end else if (start_c) begin
            ptr_q        <= '0;
            last_q       <= AW'(load_last);
            lane_q       <= 2'd0;
            words_loaded <= 9'd0;
        end else if (accept_c) begin
            lane_q <= lane_q + 2'd1;
            case (lane_q)
                2'd0:    part_q[7:0]   <= byte_in;
                2'd1:    part_q[15:8]  <= byte_in;
                2'd2:    part_q[23:16] <= byte_in;
                default: part_q        <= part_q;
            endcase
            if (word_c) begin
                words_loaded <= words_loaded + 9'd1;
                if (ptr_q != last_q) begin
                    ptr_q <= ptr_q + AW'(1);
                end
            end
        end
    end

    // Program storage; deliberately not reset so contents survive clr.
    always_ff @(posedge clk) begin
        if (word_c) begin
            mem[ptr_q] <= word_data_c;
        end
    end

    // Fetch port: zero while the core is held, otherwise a direct array read.
    assign fetch_data = core_hold ? 32'h0 : mem[AW'(fetch_addr)];

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] csum_q;

    // Running XOR of the words written in the current load.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            csum_q <= 32'h0;
        end else if (start_c) begin
            csum_q <= 32'h0;
        end else if (word_c) begin
            csum_q <= csum_q ^ word_data_c;
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = 32'h0;
`endif

endmodule
